ro_capture_sequencer: RTL and testbench

RO_CAPTURE_SEQUENCER -- requirements
Module: ro_capture_sequencer

---
 rtl/ro_pkg.sv | 17 +
 rtl/ro_window_timer.sv | 37 +++
 rtl/ro_capture_sequencer.sv | 139 +++++++++++++
 tb/tb_ro_capture_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_pkg.sv
// Shared state encoding and default sample width for the RO capture sequencer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ro_pkg;

    localparam int RO_SAMPLE_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WINDOW,
        EMIT,
        DRAIN,
        FINISH
    } ro_state_t;

endpackage

// File: rtl/ro_window_timer.sv
// Loadable down-counter that times one sampling window; expire is high while the count reads 1.
// Latency: load takes effect on the next clk; expire is decoded straight from the count register.
// Backpressure: none; the counter only moves while en is high.
module ro_window_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == WIDTH'(1));

endmodule

// File: rtl/ro_capture_sequencer.sv
// Starts the RSA victim once, then captures num_samples RO edge counts over collect_cycles-long windows.
// Latency: rsa_start one cycle after go; each sample registered on the last window cycle.
// Backpressure: EMIT holds sample_valid/sample_data until sample_ready; the next window waits for it.
module ro_capture_sequencer
    import ro_pkg::*;
#(
    parameter int SIZE_WIDTH   = 16,
    parameter int SAMPLE_WIDTH = RO_SAMPLE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    input  logic [SIZE_WIDTH-1:0]   num_samples,
    input  logic [SIZE_WIDTH-1:0]   collect_cycles,
    input  logic [SAMPLE_WIDTH-1:0] ro_count,
    output logic                    rsa_start,
    output logic [SAMPLE_WIDTH-1:0] sample_data,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    input  logic                    dma_done,
    output logic                    busy,
    output logic                    done
);

    ro_state_t               state_q, state_d;
    logic [SIZE_WIDTH-1:0]   ns_q, ns_d;
    logic [SIZE_WIDTH-1:0]   cc_q, cc_d;
    logic [SIZE_WIDTH:0]     cnt_q, cnt_d;
    logic [SAMPLE_WIDTH-1:0] base_q, base_d;
    logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
    logic                    done_q, done_d;

    logic                    tmr_load;
    logic                    tmr_en;
    logic                    tmr_expire;
    logic [SIZE_WIDTH-1:0]   win_len;

    // A zero window length still produces a one-cycle window.
    assign win_len = (cc_q == '0) ? SIZE_WIDTH'(1) : cc_q;

    ro_window_timer #(
        .WIDTH (SIZE_WIDTH)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (win_len),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        ns_d     = ns_q;
        cc_d     = cc_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        sample_d = sample_q;
        done_d   = done_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (go) begin
                    ns_d    = num_samples;
                    cc_d    = collect_cycles;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    state_d = (num_samples == '0) ? FINISH : START;
                end
            end
            START: begin
                base_d   = ro_count;
                tmr_load = 1'b1;
                state_d  = WINDOW;
            end
            WINDOW: begin
                tmr_en = 1'b1;
                if (tmr_expire) begin
                    // Modular subtraction absorbs a wrap of the free-running counter.
                    sample_d = ro_count - base_q;
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                if (sample_ready) begin
                    cnt_d = cnt_q + (SIZE_WIDTH + 1)'(1);
                    if (cnt_d == {1'b0, ns_q}) begin
                        state_d = DRAIN;
                    end else begin
                        base_d   = ro_count;
                        tmr_load = 1'b1;
                        state_d  = WINDOW;
                    end
                end
            end
            DRAIN: begin
                if (dma_done) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ns_q     <= '0;
            cc_q     <= '0;
            cnt_q    <= '0;
            base_q   <= '0;
            sample_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ns_q     <= ns_d;
            cc_q     <= cc_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            sample_q <= sample_d;
            done_q   <= done_d;
        end
    end

    assign rsa_start    = (state_q == START);
    assign sample_valid = (state_q == EMIT);
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign sample_data  = sample_q;

endmodule

// File: tb/tb_ro_capture_sequencer.sv
// Scoreboard bench for ro_capture_sequencer: expected samples queued at go, checked on each handshake.
module tb_ro_capture_sequencer;

    localparam int SW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic [SW-1:0] num_samples;
    logic [SW-1:0] collect_cycles;
    logic [DW-1:0] ro_count = '0;
    logic          rsa_start;
    logic [DW-1:0] sample_data;
    logic          sample_valid;
    logic          sample_ready;
    logic          dma_done;
    logic          busy;
    logic          done;

    logic          ro_set;
    logic [DW-1:0] ro_set_val;
    logic [DW-1:0] ro_inc;

    int n_tests = 0;
    int n_fail  = 0;
    int rsa_cnt = 0;
    int hs_cnt  = 0;
    int vld_cnt = 0;
    int rsa_base, hs_base, vld_base;

    logic [DW-1:0] exp_q[$];
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_dat  = '0;

    ro_capture_sequencer #(
        .SIZE_WIDTH   (SW),
        .SAMPLE_WIDTH (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .go             (go),
        .num_samples    (num_samples),
        .collect_cycles (collect_cycles),
        .ro_count       (ro_count),
        .rsa_start      (rsa_start),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .dma_done       (dma_done),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Free-running RO counter model.
    always @(posedge clk) begin
        if (ro_set) ro_count <= ro_set_val;
        else        ro_count <= ro_count + ro_inc;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pops, hold-under-stall checks, pulse counting.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (rsa_start)    rsa_cnt++;
            if (sample_valid) vld_cnt++;
            if (stall_prev) begin
                check("hold_valid", 64'(sample_valid), 64'(1));
                check("hold_data", 64'(sample_data), 64'(stall_dat));
            end
            if (sample_valid && sample_ready) begin
                hs_cnt++;
                check("sample_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) check("sample_data", 64'(sample_data), 64'(exp_q.pop_front()));
            end
            stall_prev = sample_valid && !sample_ready;
            stall_dat  = sample_data;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_capture(input int ns, input int cc, input int inc, input int stall);
        logic [DW-1:0] e;
        e = DW'(((cc == 0) ? 1 : cc) * inc);
        for (int i = 0; i < ns; i++) exp_q.push_back(e);
        ro_inc         = DW'(inc);
        sample_ready   = (stall == 0);
        rsa_base       = rsa_cnt;
        hs_base        = hs_cnt;
        vld_base       = vld_cnt;
        go             = 1'b1;
        num_samples    = SW'(ns);
        collect_cycles = SW'(cc);
        tick();
        go = 1'b0;
    endtask

    task automatic finish_capture(input string tag, input int ns, input int stall);
        int left;
        bit hit;
        left = stall;
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) break;
            if (sample_valid && !sample_ready) begin
                left--;
                if (left <= 0) sample_ready = 1'b1;
            end
            tick();
        end
        check({tag, "_all_samples"}, 64'(exp_q.size()), 64'(0));
        tick(3);
        check({tag, "_drain_busy"}, 64'(busy), 64'(1));
        check({tag, "_drain_no_done"}, 64'(done), 64'(0));
        dma_done = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) begin
                hit = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, 64'(hit), 64'(1));
        check({tag, "_idle"}, 64'(busy), 64'(0));
        dma_done     = 1'b0;
        sample_ready = 1'b1;
        check({tag, "_rsa_pulses"}, 64'(rsa_cnt - rsa_base), 64'(1));
        check({tag, "_sample_count"}, 64'(hs_cnt - hs_base), 64'(ns));
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        go             = 1'b0;
        num_samples    = '0;
        collect_cycles = '0;
        sample_ready   = 1'b1;
        dma_done       = 1'b0;
        ro_set         = 1'b1;
        ro_set_val     = '0;
        ro_inc         = DW'(1);
        tick(2);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_valid", 64'(sample_valid), 64'(0));
        check("rst_rsa_start", 64'(rsa_start), 64'(0));
        check("rst_sample_data", 64'(sample_data), 64'(0));
        rst    = 1'b0;
        ro_set = 1'b0;
        tick(2);

        // Basic capture.
        start_capture(3, 10, 2, 0);
        check("basic_busy", 64'(busy), 64'(1));
        finish_capture("basic", 3, 0);

        // Zero samples: done two cycles after go, nothing emitted.
        rsa_base = rsa_cnt;
        vld_base = vld_cnt;
        go = 1'b1; num_samples = '0; collect_cycles = SW'(5);
        tick();
        go = 1'b0;
        check("zero_done_cleared", 64'(done), 64'(0));
        check("zero_busy", 64'(busy), 64'(1));
        tick();
        check("zero_done", 64'(done), 64'(1));
        check("zero_idle", 64'(busy), 64'(0));
        tick(5);
        check("zero_no_rsa", 64'(rsa_cnt - rsa_base), 64'(0));
        check("zero_no_valid", 64'(vld_cnt - vld_base), 64'(0));
        check("zero_done_held", 64'(done), 64'(1));

        // Backpressure on the first sample.
        start_capture(2, 4, 3, 5);
        finish_capture("stall", 2, 5);

        // RO counter wraps inside the window.
        ro_set = 1'b1; ro_set_val = 32'hFFFF_FFF0; ro_inc = DW'(1);
        tick();
        ro_set = 1'b0;
        start_capture(1, 32, 1, 0);
        finish_capture("wrap", 1, 0);

        // collect_cycles = 0 gives a one-cycle window.
        start_capture(2, 0, 5, 0);
        finish_capture("cc_zero", 2, 0);

        // go while busy plus input changes mid-capture.
        start_capture(2, 6, 1, 0);
        tick(3);
        go = 1'b1; num_samples = SW'(5); collect_cycles = SW'(20);
        tick();
        go = 1'b0;
        finish_capture("busy_go", 2, 0);

        // Reset mid-window, then a clean restart.
        start_capture(2, 50, 1, 0);
        tick(10);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_valid", 64'(sample_valid), 64'(0));
        tick(2);
        exp_q.delete();
        rst = 1'b0;
        tick(60);
        check("post_rst_no_sample", 64'(vld_cnt - vld_base), 64'(0));
        check("post_rst_idle", 64'(busy), 64'(0));
        start_capture(1, 7, 1, 0);
        finish_capture("restart", 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
